// File: rtl/round_ctrl_if.sv
// round_ctrl_if: handshake/status bundle between the round sequencer, game/input layer, seconds counter and HUD.
interface round_ctrl_if;
    logic       start_i;
    logic       pause_tgl_i;
    logic       p1_ko_i;
    logic       p2_ko_i;
    logic [6:0] p1_hp_i;
    logic [6:0] p2_hp_i;
    logic [7:0] elapsed_i;
    logic       timer_en_o;
    logic       fight_active_o;
    logic [2:0] state_o;
    logic [7:0] time_left_o;
    logic [2:0] round_o;
    logic [1:0] p1_wins_o;
    logic [1:0] p2_wins_o;
    logic [1:0] round_winner_o;
    logic [1:0] match_winner_o;

    modport master (
        output start_i, pause_tgl_i, p1_ko_i, p2_ko_i, p1_hp_i, p2_hp_i, elapsed_i,
        input  timer_en_o, fight_active_o, state_o, time_left_o, round_o,
               p1_wins_o, p2_wins_o, round_winner_o, match_winner_o
    );

    modport slave (
        input  start_i, pause_tgl_i, p1_ko_i, p2_ko_i, p1_hp_i, p2_hp_i, elapsed_i,
        output timer_en_o, fight_active_o, state_o, time_left_o, round_o,
               p1_wins_o, p2_wins_o, round_winner_o, match_winner_o
    );
endinterface

// File: rtl/round_ctrl.sv
// round_ctrl: round/match sequencer driving the seconds-counter enable, round countdown and win tally.
// Define ROUND_CTRL_PAUSE_EN to enable the FIGHT/PAUSE toggle.
module round_ctrl #(
    parameter int CLK_FREQ_HZ   = 60_000_000,
    parameter int ROUND_SECS    = 60,
    parameter int INTRO_SECS    = 3,
    parameter int RESULT_SECS   = 2,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    round_ctrl_if.slave bus
);
    localparam int TW = CLK_FREQ_HZ > 1 ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_FREQ_HZ - 1);
    localparam logic [7:0] SECS = 8'(ROUND_SECS);

    typedef enum logic [2:0] {IDLE, INTRO, FIGHT, PAUSE, RESULT, MATCH_END} state_t;

    state_t        state, nstate;
    logic [7:0]    base, n_base, tleft, n_tleft, tl_calc, hsec;
    logic [TW-1:0] htick;
    logic [2:0]    round, n_round;
    logic [1:0]    p1w, n_p1w, p2w, n_p2w, rwin, n_rwin, mwin, n_mwin, res;
    logic          ko, timeup, hold_done, match_over, timer_en, fight_active;

    assign ko         = bus.p1_ko_i | bus.p2_ko_i;
    assign timeup     = bus.elapsed_i >= base;
    assign tl_calc    = timeup ? 8'd0 : base - bus.elapsed_i;
    // {p1_ko, p2_ko} already encodes the winner: the player who did not fall
    assign res        = ko ? {bus.p1_ko_i, bus.p2_ko_i} :
                        bus.p1_hp_i > bus.p2_hp_i ? 2'b01 :
                        bus.p1_hp_i < bus.p2_hp_i ? 2'b10 : 2'b11;
    assign hold_done  = htick == TICK_LAST &&
                        hsec == (state == INTRO ? 8'(INTRO_SECS - 1) : 8'(RESULT_SECS - 1));
    assign match_over = p1w >= 2'(ROUNDS_TO_WIN) || p2w >= 2'(ROUNDS_TO_WIN) ||
                        round >= 3'(MAX_ROUNDS);

    always_comb begin
        nstate  = state;
        n_base  = base;
        n_tleft = state == FIGHT ? tl_calc : tleft;
        n_round = round;
        n_p1w   = p1w;
        n_p2w   = p2w;
        n_rwin  = rwin;
        n_mwin  = mwin;
        case (state)
            IDLE, MATCH_END: if (bus.start_i) begin
                nstate  = INTRO;
                n_round = 3'd1;
                n_p1w   = '0;
                n_p2w   = '0;
                n_rwin  = '0;
                n_mwin  = '0;
                n_base  = SECS;
                n_tleft = SECS;
            end
            INTRO: if (hold_done) nstate = FIGHT;
            FIGHT: if (ko || timeup) begin
                nstate = RESULT;
                n_rwin = res;
                n_p1w  = (res == 2'b01 && p1w != 2'd3) ? p1w + 2'd1 : p1w;
                n_p2w  = (res == 2'b10 && p2w != 2'd3) ? p2w + 2'd1 : p2w;
            end
`ifdef ROUND_CTRL_PAUSE_EN
            else if (bus.pause_tgl_i) begin
                nstate = PAUSE;
                n_base = tl_calc;
            end
            PAUSE: if (bus.pause_tgl_i) nstate = FIGHT;
`endif
            RESULT: if (hold_done) begin
                if (match_over) begin
                    nstate = MATCH_END;
                    n_mwin = p1w > p2w ? 2'b01 : p2w > p1w ? 2'b10 : 2'b11;
                end else begin
                    nstate  = INTRO;
                    n_round = round + 3'd1;
                    n_base  = SECS;
                    n_tleft = SECS;
                    n_rwin  = '0;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            base         <= SECS;
            tleft        <= SECS;
            round        <= '0;
            p1w          <= '0;
            p2w          <= '0;
            rwin         <= '0;
            mwin         <= '0;
            timer_en     <= 1'b0;
            fight_active <= 1'b0;
        end else begin
            state        <= nstate;
            base         <= n_base;
            tleft        <= n_tleft;
            round        <= n_round;
            p1w          <= n_p1w;
            p2w          <= n_p2w;
            rwin         <= n_rwin;
            mwin         <= n_mwin;
            timer_en     <= nstate == FIGHT;
            fight_active <= nstate == FIGHT;
        end
    end

    // hold timer restarts on every state change so INTRO/RESULT get exact lengths
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            htick <= '0;
            hsec  <= '0;
        end else if (nstate != state) begin
            htick <= '0;
            hsec  <= '0;
        end else if (htick == TICK_LAST) begin
            htick <= '0;
            hsec  <= hsec + 8'd1;
        end else begin
            htick <= htick + 1'b1;
        end
    end

    assign bus.timer_en_o     = timer_en;
    assign bus.fight_active_o = fight_active;
    assign bus.state_o        = state;
    assign bus.time_left_o    = tleft;
    assign bus.round_o        = round;
    assign bus.p1_wins_o      = p1w;
    assign bus.p2_wins_o      = p2w;
    assign bus.round_winner_o = rwin;
    assign bus.match_winner_o = mwin;
endmodule
